// File: rtl/spi_eeprom_bridge_if.sv
// spi_eeprom_bridge_if: parallel byte bus between a CPU-side requester
// and the SPI EEPROM bridge (start/ready handshake).
interface spi_eeprom_bridge_if;
    logic [15:0] address;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        start;
    logic        write_enable;
    logic        ready;

    modport master (
        output address,
        output data_in,
        output start,
        output write_enable,
        input  data_out,
        input  ready
    );

    modport slave (
        input  address,
        input  data_in,
        input  start,
        input  write_enable,
        output data_out,
        output ready
    );
endinterface

// File: rtl/spi_eeprom_bridge.sv
// spi_eeprom_bridge: single-byte read/write requests turned into 25LC-style
// SPI mode-0 transactions; writes run WREN, WRITE, then RDSR polling.
module spi_eeprom_bridge #(
    parameter int CLK_DIV = 2
) (
    input  logic               clk,
    input  logic               reset,
    spi_eeprom_bridge_if.slave bus,
    output logic               spi_cs,
    output logic               spi_clk,
    output logic               spi_do,
    input  logic               spi_di
);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
    typedef enum logic [1:0] {P_READ, P_WREN, P_WRITE, P_POLL} phase_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state;
    phase_t      phase;
    phase_t      nxt_phase;
    logic [30:0] shreg;
    logic [5:0]  bit_cnt;
    logic [7:0]  div;
    logic [7:0]  cap;
    logic [15:0] addr_q;
    logic [7:0]  data_q;

    logic        launch;
    logic        finish;
    logic [15:0] nxt_addr;
    logic [7:0]  nxt_data;
    logic [31:0] nxt_frame;
    logic [5:0]  nxt_last;

    always_comb begin
        launch    = 1'b0;
        finish    = 1'b0;
        nxt_phase = phase;
        nxt_addr  = addr_q;
        nxt_data  = data_q;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    launch    = 1'b1;
                    nxt_phase = bus.write_enable ? P_WREN : P_READ;
                    nxt_addr  = bus.address;
                    nxt_data  = bus.data_in;
                end
            end
            GAP: begin
                if (div == DIV_LAST) begin
                    unique case (phase)
                        P_WREN: begin
                            launch    = 1'b1;
                            nxt_phase = P_WRITE;
                        end
                        P_WRITE: begin
                            launch    = 1'b1;
                            nxt_phase = P_POLL;
                        end
                        P_POLL: begin
                            // cap[0] is the WIP bit of the last status byte
                            launch = cap[0];
                            finish = ~cap[0];
                        end
                        P_READ: finish = 1'b1;
                    endcase
                end
            end
            default: ;
        endcase
    end

    // Frames are left-aligned; nxt_last is the bit count minus one.
    always_comb begin
        nxt_frame = {8'h05, 24'h0};
        nxt_last  = 6'd15;
        unique case (nxt_phase)
            P_READ: begin
                nxt_frame = {8'h03, nxt_addr, 8'h00};
                nxt_last  = 6'd31;
            end
            P_WREN: begin
                nxt_frame = {8'h06, 24'h0};
                nxt_last  = 6'd7;
            end
            P_WRITE: begin
                nxt_frame = {8'h02, nxt_addr, nxt_data};
                nxt_last  = 6'd31;
            end
            P_POLL: begin
                nxt_frame = {8'h05, 24'h0};
                nxt_last  = 6'd15;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            phase        <= P_READ;
            shreg        <= '0;
            bit_cnt      <= '0;
            div          <= '0;
            cap          <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            spi_cs       <= 1'b1;
            spi_clk      <= 1'b0;
            spi_do       <= 1'b0;
            bus.ready    <= 1'b1;
            bus.data_out <= 8'h00;
        end else if (launch) begin
            state     <= SHIFT;
            phase     <= nxt_phase;
            addr_q    <= nxt_addr;
            data_q    <= nxt_data;
            shreg     <= nxt_frame[30:0];
            spi_do    <= nxt_frame[31];
            bit_cnt   <= nxt_last;
            div       <= '0;
            spi_cs    <= 1'b0;
            spi_clk   <= 1'b0;
            bus.ready <= 1'b0;
        end else if (finish) begin
            state     <= DONE;
            bus.ready <= 1'b1;
            if (phase == P_READ) begin
                bus.data_out <= cap;
            end
        end else begin
            unique case (state)
                IDLE: ;
                DONE: state <= IDLE;
                SHIFT: begin
                    if (div == DIV_LAST) begin
                        div <= '0;
                        if (!spi_clk) begin
                            spi_clk <= 1'b1;
                            cap     <= {cap[6:0], spi_di};
                        end else if (bit_cnt == 6'd0) begin
                            spi_clk <= 1'b0;
                            spi_cs  <= 1'b1;
                            spi_do  <= 1'b0;
                            state   <= GAP;
                        end else begin
                            spi_clk <= 1'b0;
                            bit_cnt <= bit_cnt - 6'd1;
                            spi_do  <= shreg[30];
                            shreg   <= {shreg[29:0], 1'b0};
                        end
                    end else begin
                        div <= div + 8'd1;
                    end
                end
                GAP: div <= div + 8'd1;
            endcase
        end
    end

endmodule
